// File: rtl/pkt_rr_scheduler_pkg.sv
// Shared types and defaults for the packet round-robin scheduler.
package pkt_sched_pkg;

    localparam int PKT_LEN_W = 4;

    typedef logic [PKT_LEN_W-1:0] pkt_len_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_t;

endpackage

// File: rtl/pkt_rr_scheduler_pick.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    always_comb begin
        int unsigned cand;
        any_req = 1'b0;
        winner  = '0;
        gnt     = '0;
        cand    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                winner  = ID_W'(cand);
            end
        end
        if (en && any_req) begin
            gnt[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/pkt_rr_scheduler.sv
// Packet-granular round-robin scheduler: grants one source per packet and
// sequences its len+1 beats onto the shared sop/vld/eop/len stream.
module pkt_rr_scheduler
    import pkt_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = PKT_LEN_W,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    input  logic                     out_rdy,
    output logic                     sop,
    output logic                     vld,
    output logic                     eop,
    output logic [LEN_W-1:0]         len,
    output logic [ID_W-1:0]          src_id
);

    sched_state_t     state;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] len_q;
    logic [ID_W-1:0]  src_q;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  winner;
    logic             any_req;
    logic             accept;
    logic             grant_en;
    logic             grant;

    assign vld    = (state == XFER);
    assign sop    = vld && (beat_cnt == '0);
    assign eop    = vld && (beat_cnt == len_q);
    assign len    = len_q;
    assign src_id = src_q;

    assign accept = vld && out_rdy;
    // Granting on the eop-accept cycle lets the next sop follow with no gap.
    assign grant_en = !rst && ((state == IDLE) || (accept && eop));
    assign grant    = grant_en && any_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .en      (grant_en),
        .gnt     (gnt),
        .winner  (winner),
        .any_req (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            len_q    <= '0;
            src_q    <= '0;
            ptr      <= '0;
        end else if (grant) begin
            state    <= XFER;
            beat_cnt <= '0;
            len_q    <= req_len[winner*LEN_W +: LEN_W];
            src_q    <= winner;
            ptr      <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end else if (accept) begin
            if (eop) begin
                state <= IDLE;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Stream rules on the shared output.
    a_sop_vld: assert property (@(posedge clk) disable iff (rst) sop |-> vld);
    a_eop_vld: assert property (@(posedge clk) disable iff (rst) eop |-> vld);
    a_len_hold: assert property (@(posedge clk) disable iff (rst)
                                 (vld && !eop) |=> $stable(len));
    a_gnt_1hot: assert property (@(posedge clk) $onehot0(gnt));

endmodule

// File: tb/tb_pkt_rr_scheduler.sv
// Directed self-checking bench for pkt_rr_scheduler (NUM_REQ=4, LEN_W=4).
module tb_pkt_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic [3:0]  gnt;
    logic        out_rdy;
    logic        sop;
    logic        vld;
    logic        eop;
    logic [3:0]  len;
    logic [1:0]  src_id;

    int total;
    int bad;

    // Observation vector: {gnt[3:0], vld, sop, eop, len[3:0], src_id[1:0]}
    logic [12:0] obs;
    assign obs = {gnt, vld, sop, eop, len, src_id};

    pkt_rr_scheduler #(
        .NUM_REQ (4),
        .LEN_W   (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_len (req_len),
        .gnt     (gnt),
        .out_rdy (out_rdy),
        .sop     (sop),
        .vld     (vld),
        .eop     (eop),
        .len     (len),
        .src_id  (src_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        req     = '0;
        out_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst     = 1'b1;
        req     = 4'b1111;
        req_len = 16'h3210;
        out_rdy = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (obs !== 13'b0) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=%b", obs, 13'b0);
        end
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (obs !== 13'b0) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=%b", obs, 13'b0);
        end
    endtask

    // Each row: stim = {rst, out_rdy, req[3:0]}, exp = expected obs in that cycle.
    task automatic test_single_len2();
        logic [5:0]  stim [5];
        logic [12:0] exp  [5];
        do_reset();
        req_len = 16'h0002;
        stim = '{6'b01_0001, 6'b01_0000, 6'b01_0000, 6'b01_0000, 6'b01_0000};
        exp  = '{{4'b0001, 3'b000, 4'd0, 2'd0},
                 {4'b0000, 3'b110, 4'd2, 2'd0},
                 {4'b0000, 3'b100, 4'd2, 2'd0},
                 {4'b0000, 3'b101, 4'd2, 2'd0},
                 {4'b0000, 3'b000, 4'd2, 2'd0}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            {rst, out_rdy, req} = stim[i];
            #1;
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL single_len2 cyc%0d got=%b exp=%b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_all_four();
        logic [5:0]  stim [14];
        logic [12:0] exp  [14];
        do_reset();
        req_len = 16'h3210;
        stim = '{6'b01_1111, 6'b01_1110, 6'b01_1100, 6'b01_1100, 6'b01_1000,
                 6'b01_1000, 6'b01_1000, 6'b01_0000, 6'b01_0000, 6'b01_0000,
                 6'b01_0000, 6'b01_0011, 6'b01_0000, 6'b01_0000};
        exp  = '{{4'b0001, 3'b000, 4'd0, 2'd0},
                 {4'b0010, 3'b111, 4'd0, 2'd0},
                 {4'b0000, 3'b110, 4'd1, 2'd1},
                 {4'b0100, 3'b101, 4'd1, 2'd1},
                 {4'b0000, 3'b110, 4'd2, 2'd2},
                 {4'b0000, 3'b100, 4'd2, 2'd2},
                 {4'b1000, 3'b101, 4'd2, 2'd2},
                 {4'b0000, 3'b110, 4'd3, 2'd3},
                 {4'b0000, 3'b100, 4'd3, 2'd3},
                 {4'b0000, 3'b100, 4'd3, 2'd3},
                 {4'b0000, 3'b101, 4'd3, 2'd3},
                 {4'b0001, 3'b000, 4'd3, 2'd3},
                 {4'b0000, 3'b111, 4'd0, 2'd0},
                 {4'b0000, 3'b000, 4'd0, 2'd0}};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            {rst, out_rdy, req} = stim[i];
            #1;
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL all_four cyc%0d got=%b exp=%b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_len0();
        logic [5:0]  stim [3];
        logic [12:0] exp  [3];
        do_reset();
        req_len = 16'h0000;
        stim = '{6'b01_0010, 6'b01_0000, 6'b01_0000};
        exp  = '{{4'b0010, 3'b000, 4'd0, 2'd0},
                 {4'b0000, 3'b111, 4'd0, 2'd1},
                 {4'b0000, 3'b000, 4'd0, 2'd1}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {rst, out_rdy, req} = stim[i];
            #1;
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL len0 cyc%0d got=%b exp=%b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0]  stim [16];
        logic [12:0] exp  [16];
        do_reset();
        req_len = 16'h0005;
        stim = '{6'b01_0001, 6'b00_0000, 6'b01_0000, 6'b00_0000, 6'b00_0000,
                 6'b01_0000, 6'b00_0000, 6'b00_0000, 6'b01_0000, 6'b00_0000,
                 6'b00_0000, 6'b01_0000, 6'b01_0000, 6'b00_0000, 6'b01_0000,
                 6'b01_0000};
        exp  = '{{4'b0001, 3'b000, 4'd0, 2'd0},
                 {4'b0000, 3'b110, 4'd5, 2'd0},
                 {4'b0000, 3'b110, 4'd5, 2'd0},
                 {4'b0000, 3'b100, 4'd5, 2'd0},
                 {4'b0000, 3'b100, 4'd5, 2'd0},
                 {4'b0000, 3'b100, 4'd5, 2'd0},
                 {4'b0000, 3'b100, 4'd5, 2'd0},
                 {4'b0000, 3'b100, 4'd5, 2'd0},
                 {4'b0000, 3'b100, 4'd5, 2'd0},
                 {4'b0000, 3'b100, 4'd5, 2'd0},
                 {4'b0000, 3'b100, 4'd5, 2'd0},
                 {4'b0000, 3'b100, 4'd5, 2'd0},
                 {4'b0000, 3'b100, 4'd5, 2'd0},
                 {4'b0000, 3'b101, 4'd5, 2'd0},
                 {4'b0000, 3'b101, 4'd5, 2'd0},
                 {4'b0000, 3'b000, 4'd5, 2'd0}};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            {rst, out_rdy, req} = stim[i];
            #1;
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL backpressure cyc%0d got=%b exp=%b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_mid_arrival();
        logic [5:0]  stim [10];
        logic [12:0] exp  [10];
        do_reset();
        req_len = 16'h0410;
        stim = '{6'b01_0100, 6'b01_0000, 6'b01_0010, 6'b01_0010, 6'b01_0010,
                 6'b01_0110, 6'b01_0100, 6'b01_0100, 6'b01_0000, 6'b01_0000};
        exp  = '{{4'b0100, 3'b000, 4'd0, 2'd0},
                 {4'b0000, 3'b110, 4'd4, 2'd2},
                 {4'b0000, 3'b100, 4'd4, 2'd2},
                 {4'b0000, 3'b100, 4'd4, 2'd2},
                 {4'b0000, 3'b100, 4'd4, 2'd2},
                 {4'b0010, 3'b101, 4'd4, 2'd2},
                 {4'b0000, 3'b110, 4'd1, 2'd1},
                 {4'b0100, 3'b101, 4'd1, 2'd1},
                 {4'b0000, 3'b110, 4'd4, 2'd2},
                 {4'b0000, 3'b100, 4'd4, 2'd2}};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            {rst, out_rdy, req} = stim[i];
            #1;
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL mid_arrival cyc%0d got=%b exp=%b", i, obs, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [5:0]  stim [11];
        logic [12:0] exp  [11];
        do_reset();
        req_len = 16'h2073;
        stim = '{6'b01_0010, 6'b01_0000, 6'b01_0000, 6'b01_0000, 6'b11_0000,
                 6'b01_1001, 6'b01_1000, 6'b01_1000, 6'b01_1000, 6'b01_1000,
                 6'b01_0000};
        exp  = '{{4'b0010, 3'b000, 4'd0, 2'd0},
                 {4'b0000, 3'b110, 4'd7, 2'd1},
                 {4'b0000, 3'b100, 4'd7, 2'd1},
                 {4'b0000, 3'b100, 4'd7, 2'd1},
                 {4'b0000, 3'b100, 4'd7, 2'd1},
                 {4'b0001, 3'b000, 4'd0, 2'd0},
                 {4'b0000, 3'b110, 4'd3, 2'd0},
                 {4'b0000, 3'b100, 4'd3, 2'd0},
                 {4'b0000, 3'b100, 4'd3, 2'd0},
                 {4'b1000, 3'b101, 4'd3, 2'd0},
                 {4'b0000, 3'b110, 4'd2, 2'd3}};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            {rst, out_rdy, req} = stim[i];
            #1;
            total++;
            if (obs !== exp[i]) begin
                bad++;
                $display("FAIL reset_mid_pkt cyc%0d got=%b exp=%b", i, obs, exp[i]);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        req     = '0;
        req_len = '0;
        out_rdy = 1'b1;
        test_reset();
        test_single_len2();
        test_all_four();
        test_len0();
        test_backpressure();
        test_mid_arrival();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
